// File: rtl/dz_count_ctrl.sv
// Countdown sequencer and row-scan generator for the 8x8 bicolor dot-matrix display.
// Drives the digit code, run/done/blink status and the row multiplex index/strobe.
module dz_count_ctrl #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned START_VAL = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       clr,
  output logic [2:0] num,
  output logic       running,
  output logic       done,
  output logic       blink,
  output logic [2:0] scan_row,
  output logic       scan_en
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [2:0]    START_NUM = 3'(START_VAL);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    PAUSED,
    DONE
  } state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] scan_cnt;

  // Priority clr > start > pause is encoded by the if/else order below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      num      <= START_NUM;
      tick_cnt <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      blink    <= 1'b0;
    end else if (clr) begin
      state    <= IDLE;
      num      <= START_NUM;
      tick_cnt <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      blink    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          num      <= START_NUM;
          tick_cnt <= '0;
          if (start) begin
            state   <= COUNT;
            running <= 1'b1;
          end
        end
        COUNT: begin
          if (start) begin
            num      <= START_NUM;
            tick_cnt <= '0;
          end else if (pause) begin
            state <= PAUSED;
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            num      <= num - 3'd1;
            if (num == 3'd1) begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
              blink   <= 1'b0;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        PAUSED: begin
          // The release cycle is spent here, so the held tick_cnt resumes unchanged.
          if (start) begin
            state    <= COUNT;
            num      <= START_NUM;
            tick_cnt <= '0;
          end else if (!pause) begin
            state <= COUNT;
          end
        end
        DONE: begin
          if (start) begin
            state    <= COUNT;
            num      <= START_NUM;
            tick_cnt <= '0;
            blink    <= 1'b0;
            done     <= 1'b0;
            running  <= 1'b1;
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            blink    <= ~blink;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          num      <= START_NUM;
          tick_cnt <= '0;
          running  <= 1'b0;
          done     <= 1'b0;
          blink    <= 1'b0;
        end
      endcase
    end
  end

  // Row scan is free-running and independent of the countdown state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_row <= '0;
      scan_en  <= 1'b0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_row <= scan_row + 3'd1;
      scan_en  <= 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      scan_en  <= 1'b0;
    end
  end

endmodule
